// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models fixed MD latency and raises the D-stage stall.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU (ops 9-12); otherwise those codes act as NOPs.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic        Start,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_MD,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] HILO_out
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t             state;
    state_t             next_state;
    logic [3:0]         count;
    logic [31:0]        ph;
    logic [31:0]        pl;
    logic               is_mult;
    logic               is_div;
    logic               is_long;
    logic               issue;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        q_s;
    logic [31:0]        r_s;
    logic [31:0]        q_u;
    logic [31:0]        r_u;
    logic [63:0]        result;

    always_comb begin
        is_mult = (Op == 4'd1) || (Op == 4'd2);
        is_div  = (Op == 4'd3) || (Op == 4'd4);
`ifdef MDU_MADD_EN
        is_mult = is_mult || ((Op >= 4'd9) && (Op <= 4'd12));
`endif
        is_long = is_mult || is_div;
        issue   = Start && !Req && (state == IDLE);
    end

    // Division by zero and the single signed overflow case are fixed by the ISA, not left to the divider.
    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'b0, A} * {32'b0, B};
        q_s    = 32'hFFFF_FFFF;
        r_s    = A;
        q_u    = 32'hFFFF_FFFF;
        r_u    = A;
        if (B != 32'd0) begin
            q_u = A / B;
            r_u = A % B;
            if ((A == 32'h8000_0000) && (B == 32'hFFFF_FFFF)) begin
                q_s = 32'h8000_0000;
                r_s = 32'd0;
            end else begin
                q_s = $signed(A) / $signed(B);
                r_s = $signed(A) % $signed(B);
            end
        end
        result = 64'd0;
        case (Op)
            4'd1:    result = $unsigned(prod_s);
            4'd2:    result = prod_u;
            4'd3:    result = {r_s, q_s};
            4'd4:    result = {r_u, q_u};
`ifdef MDU_MADD_EN
            4'd9:    result = {HI, LO} + $unsigned(prod_s);
            4'd10:   result = {HI, LO} + prod_u;
            4'd11:   result = {HI, LO} - $unsigned(prod_s);
            4'd12:   result = {HI, LO} - prod_u;
`endif
            default: result = 64'd0;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (issue && is_long) next_state = BUSY;
            BUSY:    if (count == 4'd0)    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Result is captured at issue so later operand changes cannot leak into the commit.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count <= 4'd0;
            ph    <= 32'd0;
            pl    <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        if (is_long) begin
                            {ph, pl} <= result;
                            count    <= is_mult ? MULT_LOAD : DIV_LOAD;
                        end else if (Op == 4'd5) begin
                            HI <= A;
                        end else if (Op == 4'd6) begin
                            LO <= A;
                        end
                    end
                end
                BUSY: begin
                    if (count == 4'd0) begin
                        HI <= ph;
                        LO <= pl;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: count <= 4'd0;
            endcase
        end
    end

    always_comb begin
        Busy     = (state == BUSY);
        Stall    = D_MD && (Busy || (Start && is_long && !Req));
        HILO_out = (Op == 4'd7) ? HI : LO;
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomised scoreboard bench for mdu_ctrl: a plain-arithmetic model predicts HI/LO and latency,
// and a monitor checks each commit when Busy drops.
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Req;
    logic        Start;
    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        D_MD;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] HILO_out;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Start(Start), .Op(Op), .A(A), .B(B),
        .D_MD(D_MD), .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO), .HILO_out(HILO_out)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] mhi   = 32'd0;
    logic [31:0] mlo   = 32'd0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit isLong(input logic [3:0] op);
        bit l;
        l = (op >= 4'd1) && (op <= 4'd4);
`ifdef MDU_MADD_EN
        l = l || ((op >= 4'd9) && (op <= 4'd12));
`endif
        return l;
    endfunction

    // Architectural result {HI,LO} of a long op, straight from the ISA arithmetic rules.
    function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, qv, rv, ps, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ps = sa * sb;
        pu = ua * ub;
        case (op)
            4'd1: return ps;
            4'd2: return pu;
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q  = sa / sb;
                r  = sa - q * sb;
                qv = q;
                rv = r;
                return {rv[31:0], qv[31:0]};
            end
            4'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                qv = ua / ub;
                rv = ua % ub;
                return {rv[31:0], qv[31:0]};
            end
            4'd9:  return {hi, lo} + ps;
            4'd10: return {hi, lo} + pu;
            4'd11: return {hi, lo} - ps;
            4'd12: return {hi, lo} - pu;
            default: return {hi, lo};
        endcase
    endfunction

    // Monitor: measures Busy width and checks HI/LO against the scoreboard on each falling Busy.
    bit   prevBusy = 1'b0;
    int   busyCnt  = 0;
    exp_t mexp;
    always @(negedge Clk) begin
        if (Rst) begin
            prevBusy = 1'b0;
            busyCnt  = 0;
        end else begin
            if (Busy) begin
                busyCnt++;
            end else if (prevBusy) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL spurious_commit: got HI=%h LO=%h expected no commit", HI, LO);
                end else begin
                    mexp = sbq.pop_front();
                    checkOutput("commit_hi", HI, mexp.hi);
                    checkOutput("commit_lo", LO, mexp.lo);
                    checkOutput("busy_len", 32'(busyCnt), 32'(mexp.n));
                end
                busyCnt = 0;
            end
            prevBusy = Busy;
        end
    end

    task automatic waitIdle(input bit noise);
        for (int k = 0; k < 60; k++) begin
            if (!Busy) begin
                Start = 1'b0;
                Req   = 1'b0;
                return;
            end
            if (noise) begin
                Start = 1'($urandom_range(0, 1));
                Op    = 4'($urandom_range(1, 6));
                A     = $urandom;
                B     = $urandom;
                Req   = 1'($urandom_range(0, 1));
            end
            @(posedge Clk);
            #1;
        end
        Start = 1'b0;
        Req   = 1'b0;
        total++;
        bad++;
        $display("[TB] FAIL idle_timeout: got Busy=%b expected 0 within 60 cycles", Busy);
    endtask

    // One issue attempt from IDLE; updates the model and pushes the expected commit.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit req, input bit dmd);
        bit          lng;
        logic [63:0] r;
        exp_t        e;
        @(negedge Clk);
        Start = 1'b1; Op = op; A = a; B = b; Req = req; D_MD = dmd;
        #1;
        lng = isLong(op) && !req;
        checkOutput("stall_issue", 32'(Stall), 32'(dmd && lng));
        checkOutput("hilo_out", HILO_out, (op == 4'd7) ? mhi : mlo);
        if (lng) begin
            r    = refResult(op, a, b, mhi, mlo);
            e.hi = r[63:32];
            e.lo = r[31:0];
            e.n  = (op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N;
            sbq.push_back(e);
            mhi  = r[63:32];
            mlo  = r[31:0];
        end else if (!req && op == 4'd5) begin
            mhi = a;
        end else if (!req && op == 4'd6) begin
            mlo = a;
        end
        @(posedge Clk);
        #1;
        Start = 1'b0; Req = 1'b0; D_MD = 1'b0; Op = 4'd0;
        if (lng) begin
            checkOutput("busy_set", 32'(Busy), 32'd1);
        end else begin
            checkOutput("busy_idle", 32'(Busy), 32'd0);
            checkOutput("hi_now", HI, mhi);
            checkOutput("lo_now", LO, mlo);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Rst = 1'b1; Req = 1'b0; Start = 1'b0; D_MD = 1'b0; Op = 4'd0; A = 32'd0; B = 32'd0;
        #2;
        checkOutput("reset_busy", 32'(Busy), 32'd0);
        checkOutput("reset_hi", HI, 32'd0);
        checkOutput("reset_lo", LO, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;

        applyStimulus(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        waitIdle(1'b0);
        checkOutput("mult_hi", HI, 32'hFFFF_FFFF);
        checkOutput("mult_lo", LO, 32'hFFFF_FFFA);
        applyStimulus(4'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        waitIdle(1'b0);
        checkOutput("multu_hi", HI, 32'd2);
        checkOutput("multu_lo", LO, 32'hFFFF_FFFA);
        applyStimulus(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        waitIdle(1'b0);
        checkOutput("div_hi", HI, 32'hFFFF_FFFF);
        checkOutput("div_lo", LO, 32'hFFFF_FFFD);
        applyStimulus(4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
        waitIdle(1'b0);
        checkOutput("divu0_hi", HI, 32'd7);
        checkOutput("divu0_lo", LO, 32'hFFFF_FFFF);
        applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        waitIdle(1'b0);
        checkOutput("divovf_hi", HI, 32'd0);
        checkOutput("divovf_lo", LO, 32'h8000_0000);

        applyStimulus(4'd6, 32'd5, 32'd0, 1'b1, 1'b1);
        checkOutput("mtlo_req_lo", LO, 32'h8000_0000);
        applyStimulus(4'd6, 32'd5, 32'd0, 1'b0, 1'b1);
        checkOutput("mtlo_lo", LO, 32'd5);

        applyStimulus(4'd1, 32'd1234, 32'd77, 1'b1, 1'b1);

        // Stall window: issue cycle plus every busy cycle, released once the result commits.
        @(negedge Clk);
        Start = 1'b1; Op = 4'd1; A = $urandom; B = $urandom; D_MD = 1'b1;
        #1;
        checkOutput("stall_win_issue", 32'(Stall), 32'd1);
        begin
            logic [63:0] r;
            exp_t        e;
            r    = refResult(4'd1, A, B, mhi, mlo);
            e.hi = r[63:32];
            e.lo = r[31:0];
            e.n  = MULT_N;
            sbq.push_back(e);
            mhi  = r[63:32];
            mlo  = r[31:0];
        end
        @(posedge Clk);
        #1;
        Start = 1'b0;
        for (int i = 0; i < MULT_N; i++) begin
            checkOutput("stall_win_busy", 32'(Stall), 32'd1);
            @(posedge Clk);
            #1;
        end
        checkOutput("stall_win_end", 32'(Stall), 32'd0);
        checkOutput("stall_win_busy_end", 32'(Busy), 32'd0);
        @(negedge Clk);
        Start = 1'b1; Op = 4'd8;
        #1;
        checkOutput("mflo_value", HILO_out, mlo);
        checkOutput("mflo_stall", 32'(Stall), 32'd0);
        Op = 4'd7;
        #1;
        checkOutput("mfhi_value", HILO_out, mhi);
        @(posedge Clk);
        #1;
        Start = 1'b0; D_MD = 1'b0; Op = 4'd0;

        applyStimulus(4'd3, $urandom, 32'($urandom_range(1, 1000)), 1'b0, 1'b0);
        Req = 1'b1;
        waitIdle(1'b1);

`ifdef MDU_MADD_EN
        applyStimulus(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(4'd6, 32'd10, 32'd0, 1'b0, 1'b0);
        applyStimulus(4'd11, 32'd3, 32'd4, 1'b0, 1'b1);
        waitIdle(1'b0);
        checkOutput("msub_hi", HI, 32'hFFFF_FFFF);
        checkOutput("msub_lo", LO, 32'hFFFF_FFFE);
`else
        applyStimulus(4'd11, 32'd3, 32'd4, 1'b0, 1'b1);
`endif

        for (int it = 0; it < 80; it++) begin
            logic [3:0] op;
            bit         rq;
            op = 4'($urandom_range(0, 15));
            rq = ($urandom_range(0, 7) == 0);
            applyStimulus(op, pickOperand(), pickOperand(), rq, 1'($urandom_range(0, 1)));
            if (isLong(op) && !rq) waitIdle(1'b1);
        end

        // Reset two cycles into a MULT must drop everything, with no late commit.
        applyStimulus(4'd1, $urandom, $urandom, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        sbq.delete();
        mhi = 32'd0;
        mlo = 32'd0;
        #1;
        checkOutput("rst_mid_busy", 32'(Busy), 32'd0);
        checkOutput("rst_mid_hi", HI, 32'd0);
        checkOutput("rst_mid_lo", LO, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        checkOutput("rst_after_busy", 32'(Busy), 32'd0);
        checkOutput("rst_after_hi", HI, 32'd0);
        checkOutput("rst_after_lo", LO, 32'd0);

        @(negedge Clk);
        @(negedge Clk);
        #1;
        checkOutput("scoreboard_drain", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
